// File: rtl/serial_four_bit_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_four_bit_subtractor
//  Description : Bit-serial subtractor, LSB first. A single full-subtractor
//                cell and a borrow flip-flop compute D = A - B - borrow_in
//                over WIDTH cycles, with a start/done handshake and
//                borrow-out, signed-overflow and zero flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_four_bit_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin_n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             OV,
    output logic             Z
);

    // Counter is one bit wider than needed to index WIDTH bits, so the
    // value after the final shift (WIDTH) never wraps.
    localparam int             CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    localparam logic [0:0]     S_IDLE   = 1'b0;
    localparam logic [0:0]     S_SHIFT  = 1'b1;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_sh_q;
    logic             br_q;
    logic [CW-1:0]    cnt_q;
    // Operand sign bits are kept aside because the shift registers have
    // discarded them by the time the overflow flag is computed.
    logic             a_msb_q;
    logic             b_msb_q;

    logic [WIDTH-1:0] d_q;
    logic             bout_q;
    logic             ov_q;
    logic             z_q;
    logic             done_q;

    // ------------------------------------------------------------------
    // Full-subtractor cell and control decodes
    // ------------------------------------------------------------------
    logic             a0;
    logic             b0;
    logic             d_bit;
    logic             br_d;
    logic [WIDTH-1:0] res_d;
    logic             accept;
    logic             last_bit;

    assign a0       = a_sh_q[0];
    assign b0       = b_sh_q[0];
    assign d_bit    = a0 ^ b0 ^ br_q;
    assign br_d     = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    // New difference bit enters at the MSB; after WIDTH shifts the first
    // bit computed has travelled down to bit 0.
    assign res_d    = {d_bit, res_sh_q[WIDTH-1:1]};
    assign accept   = (state_q == S_IDLE) && start;
    assign last_bit = (state_q == S_SHIFT) && (cnt_q == LAST_CNT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: leave IDLE on start, return after the last bit
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)    state_d = S_SHIFT;
            S_SHIFT: if (last_bit) state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    // Output decode: busy exactly while bits are being processed
    always_comb begin
        busy = 1'b0;
        case (state_q)
            S_SHIFT: busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Serial datapath: load operands on accept, shift one bit per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
        end else if (accept) begin
            a_sh_q   <= A;
            b_sh_q   <= B;
            res_sh_q <= '0;
            br_q     <= ~Bin_n;
            cnt_q    <= '0;
            a_msb_q  <= A[WIDTH-1];
            b_msb_q  <= B[WIDTH-1];
        end else if (state_q == S_SHIFT) begin
            a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
            res_sh_q <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_q + CNT_ONE;
        end
    end

    // Result registers: updated only on the final bit, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q    <= '0;
            bout_q <= 1'b0;
            ov_q   <= 1'b0;
            z_q    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= last_bit;
            if (last_bit) begin
                d_q    <= res_d;
                bout_q <= br_d;
                ov_q   <= (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
                z_q    <= (res_d == '0);
            end
        end
    end

    assign done = done_q;
    assign D    = d_q;
    assign Bout = bout_q;
    assign OV   = ov_q;
    assign Z    = z_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_four_bit_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_four_bit_subtractor
//  Description : Self-checking bench for serial_four_bit_subtractor. A
//                transaction-level model predicts busy/done/results every
//                cycle; directed cases pin the model with literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_four_bit_subtractor;

    localparam int WIDTH = 4;
    localparam int MODV  = 1 << WIDTH;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin_n;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             OV;
    logic             Z;

    int n_checks = 0;
    int n_fail   = 0;

    serial_four_bit_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin_n (Bin_n),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bout  (Bout),
        .OV    (OV),
        .Z     (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: an operation is accepted when idle and
    // start is seen, takes WIDTH cycles, then publishes plain-integer
    // results for one done cycle.
    // ------------------------------------------------------------------
    int               m_left;
    logic             m_busy, m_done, m_bout, m_ov, m_z;
    logic [WIDTH-1:0] m_d;
    int               op_a, op_b, op_bin;

    function automatic int as_signed(input int v);
        return (v >= MODV / 2) ? v - MODV : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0; m_busy <= 1'b0; m_done <= 1'b0;
            m_d <= '0; m_bout <= 1'b0; m_ov <= 1'b0; m_z <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    op_a   <= int'(A);
                    op_b   <= int'(B);
                    op_bin <= Bin_n ? 0 : 1;
                    m_busy <= 1'b1;
                    m_left <= WIDTH;
                end
            end else if (m_left == 1) begin
                int diff, dm;
                diff = op_a - op_b - op_bin;
                dm   = (diff + 2 * MODV) % MODV;
                m_d    <= WIDTH'(dm);
                m_bout <= (diff < 0);
                m_ov   <= ((as_signed(op_a) < 0) != (as_signed(op_b) < 0)) &&
                          ((as_signed(dm) < 0) != (as_signed(op_a) < 0));
                m_z    <= (dm == 0);
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_left <= 0;
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        chk("busy", int'(busy), int'(m_busy));
        chk("done", int'(done), int'(m_done));
        chk("D",    int'(D),    int'(m_d));
        chk("Bout", int'(Bout), int'(m_bout));
        chk("OV",   int'(OV),   int'(m_ov));
        chk("Z",    int'(Z),    int'(m_z));
    end

    // One directed operation with literal expectations and latency check
    task automatic do_op(input int a, input int b, input int binn,
                         input int ed, input int eb, input int eo, input int ez,
                         input string tag);
        int cnt;
        @(negedge clk);
        A = WIDTH'(a); B = WIDTH'(b); Bin_n = binn[0]; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cnt = 1;
        chk({tag, "_busy_after_start"}, int'(busy), 1);
        A = WIDTH'($urandom); B = WIDTH'($urandom); Bin_n = 1'($urandom);
        while (!done && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_latency"}, cnt, WIDTH + 1);
        chk({tag, "_D"},    int'(D),    ed);
        chk({tag, "_Bout"}, int'(Bout), eb);
        chk({tag, "_OV"},   int'(OV),   eo);
        chk({tag, "_Z"},    int'(Z),    ez);
        chk({tag, "_busy_in_done"}, int'(busy), 0);
    endtask

    initial begin
        int cnt, idx, cyc, seen_done;
        rst_n = 1'b1; start = 1'b0; A = '0; B = '0; Bin_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_D",    int'(D),    0);
        chk("reset_flags", int'({Bout, OV, Z}), 0);
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b1;

        // Directed cases with hand-computed results
        do_op(7, 3, 1, 4,  0, 0, 0, "t1");
        do_op(3, 7, 1, 12, 1, 0, 0, "t2a");
        do_op(8, 1, 1, 7,  0, 1, 0, "t2b");
        do_op(5, 4, 0, 0,  0, 0, 1, "t3a");
        do_op(0, 0, 0, 15, 1, 0, 0, "t3b");

        // Start held high with operands changing mid-operation
        @(negedge clk);
        A = 4'd9; B = 4'd2; Bin_n = 1'b1; start = 1'b1;
        @(negedge clk);
        cnt = 1; A = 4'd0; B = 4'd0;
        while (!done && cnt < 20) begin @(negedge clk); cnt++; end
        chk("t4_latency", cnt, WIDTH + 1);
        chk("t4_D", int'(D), 7);
        cnt = 0;
        @(negedge clk); cnt = 1;
        while (!done && cnt < 20) begin @(negedge clk); cnt++; end
        chk("t4_back_to_back_gap", cnt, WIDTH + 1);
        chk("t4_D2", int'(D), 0);
        chk("t4_Z2", int'(Z), 1);
        start = 1'b0;
        @(negedge clk); @(negedge clk);

        // Reset in the middle of an operation
        @(negedge clk);
        A = 4'd6; B = 4'd1; Bin_n = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy", int'(busy), 0);
        chk("t5_done", int'(done), 0);
        chk("t5_D",    int'(D),    0);
        chk("t5_flags", int'({Bout, OV, Z}), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        chk("t5_no_done_after_abort", seen_done, 0);
        do_op(6, 1, 1, 5, 0, 0, 0, "t5b");

        // Exhaustive sweep, back-to-back; operands scrambled while busy
        start = 1'b1; idx = 0; cyc = 0;
        while (idx < MODV * MODV * 2 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (!busy) begin
                A = WIDTH'(idx % MODV);
                B = WIDTH'((idx / MODV) % MODV);
                Bin_n = 1'((idx / (MODV * MODV)) % 2);
                idx++;
            end else begin
                A = WIDTH'($urandom); B = WIDTH'($urandom); Bin_n = 1'($urandom);
            end
        end
        chk("sweep_completed", idx, MODV * MODV * 2);
        @(negedge clk); start = 1'b0;

        // Random traffic with random idle gaps and stray starts
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start = 1'($urandom_range(1, 0));
            A = WIDTH'($urandom); B = WIDTH'($urandom); Bin_n = 1'($urandom);
        end
        start = 1'b0;
        for (int i = 0; i < WIDTH + 3; i++) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
